// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability-counter debounce, press/release pulses.
// Optional long-press pulse is built only when BTN_LONGPRESS_EN is defined.
module btn_debounce #(
  parameter logic IDLE_LEVEL      = 1'b1,
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter int   CNT_WIDTH       = 20,
  parameter int   LONG_CYCLES     = 100000000,
  parameter int   LCNT_WIDTH      = 27
) (
  input  logic pclk,
  input  logic presetn,
  input  logic btn_raw,
  output logic btn_state,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 sync_q1;
  logic                 sync_q2;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 differs;
  logic                 settle;

  assign differs = (sync_q2 != btn_state);
  assign settle  = differs && (cnt == CNT_LAST);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      sync_q1       <= IDLE_LEVEL;
      sync_q2       <= IDLE_LEVEL;
      btn_state     <= IDLE_LEVEL;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync_q1       <= btn_raw;
      sync_q2       <= sync_q1;
      press_pulse   <= settle && (sync_q2 != IDLE_LEVEL);
      release_pulse <= settle && (sync_q2 == IDLE_LEVEL);
      if (!differs) begin
        cnt <= '0;
      end else if (settle) begin
        btn_state <= sync_q2;
        cnt       <= '0;
      end else begin
        cnt <= cnt + CNT_WIDTH'(1);
      end
    end
  end

`ifdef BTN_LONGPRESS_EN
  localparam logic [LCNT_WIDTH-1:0] LCNT_LAST = LCNT_WIDTH'(LONG_CYCLES - 1);

  logic [LCNT_WIDTH-1:0] lcnt;
  logic                  long_done;

  // Counter parks at its last value; long_done keeps the pulse to one per press.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      lcnt       <= '0;
      long_done  <= 1'b0;
      long_pulse <= 1'b0;
    end else if (btn_state == IDLE_LEVEL) begin
      lcnt       <= '0;
      long_done  <= 1'b0;
      long_pulse <= 1'b0;
    end else begin
      long_pulse <= (lcnt == LCNT_LAST) && !long_done;
      if (lcnt == LCNT_LAST) begin
        long_done <= 1'b1;
      end else begin
        lcnt <= lcnt + LCNT_WIDTH'(1);
      end
    end
  end
`else
  assign long_pulse = 1'b0;
`endif

endmodule
